// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode: up to IN_W enqueues and
// OUT_W in-order dequeues per cycle, with flush and all-or-nothing backpressure.
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [IN_W-1:0]               in_valid,
    input  logic [IN_W*PC_W-1:0]          in_pc,
    input  logic [IN_W*PC_W-1:0]          in_npc,
    input  logic [IN_W*INST_W-1:0]        in_inst,
    output logic                          in_ready,
    output logic [OUT_W-1:0]              out_valid,
    output logic [OUT_W*PC_W-1:0]         out_pc,
    output logic [OUT_W*PC_W-1:0]         out_npc,
    output logic [OUT_W*INST_W-1:0]       out_inst,
    input  logic [$clog2(OUT_W+1)-1:0]    deq_num,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Pointer and occupancy state
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Entry storage; only the valid bits carry reset
    logic [DEPTH-1:0]  mem_valid;
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [PC_W-1:0]   mem_npc  [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    // Next-state signals
    logic [CNT_W-1:0] free_slots;
    logic             enq_fire;
    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] n_deq;
    logic [CNT_W-1:0] count_next;
    logic [DEPTH-1:0] valid_next;
    logic [PTR_W-1:0] wr_idx [IN_W];
    logic [PTR_W-1:0] rd_idx [OUT_W];

    // Backpressure is derived from registered occupancy only, so IF never sees
    // a path from decode's deq_num to in_ready.
    always_comb begin
        free_slots  = CNT_W'(DEPTH) - count;
        in_ready    = free_slots >= CNT_W'(IN_W);
        almost_full = free_slots < CNT_W'(2*IN_W);
        enq_fire    = in_ready && !flush;
    end

    // Compact valid lanes: lane i lands at tail + (valid lanes below i).
    // NOTE: n_enq is a running sum inside one combinational pass, so it uses
    // blocking assignments; sequential state below uses non-blocking only.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < IN_W; i++) begin
            wr_idx[i] = tail + PTR_W'(n_enq);
            if (in_valid[i]) begin
                n_enq = n_enq + CNT_W'(1);
            end
        end
    end

    // Dequeue is clamped to occupancy so a misbehaving decoder cannot underflow
    always_comb begin
        if (CNT_W'(deq_num) > count) begin
            n_deq = count;
        end else begin
            n_deq = CNT_W'(deq_num);
        end
        count_next = count + (enq_fire ? n_enq : CNT_W'(0)) - n_deq;
    end

    // Per-slot valid update: clear the retired head slots, set the newly written ones.
    // NOTE: every variable gets its default before any conditional update, which
    // keeps this block free of inferred latches.
    always_comb begin
        valid_next = mem_valid;
        for (int k = 0; k < OUT_W; k++) begin
            if (CNT_W'(k) < n_deq) begin
                valid_next[head + PTR_W'(k)] = 1'b0;
            end
        end
        if (enq_fire) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in_valid[i]) begin
                    valid_next[wr_idx[i]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_valid <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_valid <= '0;
        end else begin
            head      <= head + PTR_W'(n_deq);
            tail      <= enq_fire ? tail + PTR_W'(n_enq) : tail;
            count     <= count_next;
            mem_valid <= valid_next;
        end
    end

    // NOTE: the payload arrays are deliberately not reset; the valid bits and
    // count decide visibility, and the outputs are gated to zero when invalid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_W; i++) begin
            if (enq_fire && in_valid[i]) begin
                mem_pc[wr_idx[i]]   <= in_pc[i*PC_W +: PC_W];
                mem_npc[wr_idx[i]]  <= in_npc[i*PC_W +: PC_W];
                mem_inst[wr_idx[i]] <= in_inst[i*INST_W +: INST_W];
            end
        end
    end

    // Output lanes read the oldest OUT_W entries straight from storage
    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_npc   = '0;
        out_inst  = '0;
        for (int k = 0; k < OUT_W; k++) begin
            rd_idx[k]    = head + PTR_W'(k);
            out_valid[k] = (count > CNT_W'(k)) && mem_valid[rd_idx[k]];
            if (out_valid[k]) begin
                out_pc[k*PC_W +: PC_W]       = mem_pc[rd_idx[k]];
                out_npc[k*PC_W +: PC_W]      = mem_npc[rd_idx[k]];
                out_inst[k*INST_W +: INST_W] = mem_inst[rd_idx[k]];
            end
        end
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised, circular instruction queue between IF and ID; replaces the fixed 4-entry, 2-wide instruction buffer.
- Accepts up to IN_W fetched instructions per cycle and presents the oldest OUT_W entries to decode. Decode retires an in-order prefix of them.
- Each entry has an explicit valid bit, so all-zero instruction words are legal.
- Flush on branch mispredict; all-or-nothing backpressure to IF.

Parameters:
- DEPTH, 8: entries; power of 2, DEPTH >= 2*IN_W.
- IN_W, 2: enqueue lanes.
- OUT_W, 2: dequeue lanes; OUT_W <= DEPTH.
- PC_W, 32: width of pc and npc.
- INST_W, 32: instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict).
- in_valid  in  IN_W  lane i carries an instruction; any bit pattern allowed.
- in_pc  in  IN_W*PC_W  lane i at [i*PC_W +: PC_W].
- in_npc  in  IN_W*PC_W  predicted next pc per lane.
- in_inst  in  IN_W*INST_W  instruction per lane.
- in_ready  out  1  queue can accept IN_W entries this cycle.
- out_valid  out  OUT_W  bit k = entry (head+k) is present.
- out_pc  out  OUT_W*PC_W  pc of entry head+k.
- out_npc  out  OUT_W*PC_W  npc of entry head+k.
- out_inst  out  OUT_W*INST_W  instruction of entry head+k.
- deq_num  in  $clog2(OUT_W+1)  number of head entries decode consumes this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  (DEPTH - count) < 2*IN_W.

Behaviour:
- Reset (rst low, asynchronous): head = tail = 0, count = 0, all entry valid bits 0.
  - Outputs: out_valid = 0, in_ready = 1, almost_full = 0, count = 0.
  - Releasing reset mid-operation leaves the queue empty; no entry survives.
- Storage: DEPTH entries of {pc, npc, inst} plus a valid bit. head and tail are $clog2(DEPTH)-bit pointers and wrap modulo DEPTH naturally.
- in_ready = (DEPTH - count) >= IN_W.
  - Computed from registered count only; slots freed by a dequeue in the same cycle are not credited.
  - Combinational from state only; no path from any input.
- Enqueue fires when in_ready && !flush.
  - n_enq = popcount(in_valid).
  - Valid lanes are compacted in ascending lane order into slots tail, tail+1, ... (mod DEPTH).
  - tail += n_enq.
  - When in_ready = 0, in_valid is ignored (nothing partially written); IF holds its lanes until in_ready = 1.
- Outputs:
  - out_valid[k] = (count > k).
  - out_* lane k reads entry (head+k) mod DEPTH.
  - Data lanes are forced to 0 when out_valid[k] = 0.
  - No combinational path from in_* to out_*; minimum enqueue-to-output latency is 1 cycle.
- Dequeue:
  - n_deq = min(deq_num, count). Clamping is a protective fallback; deq_num > count is a protocol violation flagged by a bench assertion.
  - Cleared slots: head .. head+n_deq-1.
  - head += n_deq.
- Occupancy: count_next = count + n_enq - n_deq. Simultaneous enqueue and dequeue are both applied in the same cycle.
- flush has priority over enqueue and dequeue. Next cycle: head = tail = 0, count = 0, all valid bits 0, and any in_valid presented that cycle is dropped.
- Boundaries:
  - Empty: out_valid = 0, and deq_num is clamped to 0.
  - Full (count = DEPTH): in_ready = 0; dequeue still allowed.
  - count = DEPTH - IN_W + 1: in_ready = 0 even if deq_num > 0 in the same cycle.
  - Pointer wrap: entries spanning slot DEPTH-1 to slot 0 stay in order on both enqueue and dequeue.
- count never exceeds DEPTH; verified by bench assertion.

Test Plan:
- Reset and fill: rst low then high. Then in_valid = 2'b11 with pc 0x100/0x104 each cycle, deq_num = 0.
  - Expect count 0 → 2 → 4 → 6.
  - almost_full = 1 once count = 6.
  - in_ready drops to 0 at count = 8; a 5th beat held by IF is not written.
- Sparse lanes: in_valid = 2'b10, lane1 pc = 0x200, queue empty.
  - Expect next cycle out_valid = 2'b01, out_pc lane0 = 0x200, count = 1.
- Zero instruction word: enqueue inst = 0x00000000, pc = 0, npc = 0.
  - Expect out_valid[0] = 1 and count = 1; the entry is treated as a real instruction.
- Wrap and concurrent traffic: steady state with in_valid = 2'b11 and deq_num = 2 for 20 cycles starting from count = 3.
  - Expect count stays 3.
  - out_pc sequence is strictly pc, pc+4, ... with no gaps across the wrap from slot 7 to slot 0.
- Flush priority: count = 5, assert flush together with in_valid = 2'b11 and deq_num = 2.
  - Expect next cycle count = 0, out_valid = 0, in_ready = 1.
  - Subsequent enqueue lands at head.
- Async reset mid-stream: pull rst low between clock edges at count = 4.
  - Expect out_valid = 0 and count = 0 immediately, with no clock edge required.
  - After release, the first enqueue appears on lane 0.
